// File: rtl/systolic_psum_ctrl.sv
// Partial-sum SRAM sequencer: optional clear pass, then one read per row,
// then a drain long enough for the most-skewed column to finish.
module systolic_psum_ctrl #(
    parameter int BIT_ADDR = 10,
    parameter int PE_COL   = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_Start,
    input  logic                i_Init,
    input  logic [BIT_ADDR-1:0] i_Base_Addr,
    input  logic [BIT_ADDR-1:0] i_Num_Rows,
    input  logic                i_Stall,
    output logic [BIT_ADDR-1:0] o_Psram_Addr,
    output logic [BIT_ADDR-1:0] o_Psram_Addr_1buf,
    output logic [PE_COL-1:0]   o_Psram_En,
    output logic [PE_COL-1:0]   o_Psram_Wea,
    output logic [PE_COL-1:0]   o_Psram_Valid_1buf,
    output logic                o_Busy,
    output logic                o_Done
);

    localparam int DW = $clog2(PE_COL) + 1;
    localparam logic [BIT_ADDR-1:0] ONE = 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PE_COL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic [BIT_ADDR-1:0] cnt;
    logic [BIT_ADDR-1:0] base;
    logic [BIT_ADDR-1:0] num;
    logic [DW-1:0]       drain_cnt;

    logic in_pass;
    logic issuing;
    logic last_row;

    // Comparing against N-1 lets N = 2^BIT_ADDR-1 finish without cnt overflowing.
    assign in_pass  = (state == S_CLEAR) || (state == S_RUN);
    assign issuing  = in_pass && !i_Stall;
    assign last_row = (cnt == num - ONE);

    assign o_Psram_Addr = in_pass ? base + cnt : '0;
    assign o_Psram_En   = issuing ? {PE_COL{1'b1}} : '0;
    assign o_Psram_Wea  = (issuing && state == S_CLEAR) ? {PE_COL{1'b1}} : '0;
    assign o_Busy       = (state != S_IDLE);
    assign o_Done       = (state == S_DONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            base      <= '0;
            num       <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        base <= i_Base_Addr;
                        num  <= i_Num_Rows;
                        cnt  <= '0;
                        if (i_Num_Rows == '0) state <= S_DONE;
                        else if (i_Init)      state <= S_CLEAR;
                        else                  state <= S_RUN;
                    end
                end
                S_CLEAR: begin
                    if (issuing) begin
                        if (last_row) begin
                            state <= S_RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                S_RUN: begin
                    if (issuing) begin
                        if (last_row) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) state <= S_DONE;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write-back side: clear writes never raise a valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_Psram_Addr_1buf  <= '0;
            o_Psram_Valid_1buf <= '0;
        end else begin
            o_Psram_Addr_1buf  <= o_Psram_Addr;
            o_Psram_Valid_1buf <= (state == S_RUN) ? o_Psram_En : '0;
        end
    end

endmodule

// File: tb/tb_systolic_psum_ctrl.sv
// Directed bench for systolic_psum_ctrl: per-cycle capture of a pass,
// then hand-computed expectations checked inline per scenario.
module tb_systolic_psum_ctrl;

    logic       CLK;
    logic       RST;
    logic       i_Start;
    logic       i_Init;
    logic [9:0] i_Base_Addr;
    logic [9:0] i_Num_Rows;
    logic       i_Stall;
    logic [9:0] o_Psram_Addr;
    logic [9:0] o_Psram_Addr_1buf;
    logic [3:0] o_Psram_En;
    logic [3:0] o_Psram_Wea;
    logic [3:0] o_Psram_Valid_1buf;
    logic       o_Busy;
    logic       o_Done;

    int errors = 0;
    int checks = 0;

    localparam int MAXC = 1100;
    bit         stall_mask [0:MAXC];
    bit         inj_mask   [0:MAXC];
    logic [9:0] addr_a     [0:MAXC];
    logic [9:0] addr1_a    [0:MAXC];
    logic [3:0] en_a       [0:MAXC];
    logic [3:0] wea_a      [0:MAXC];
    logic [3:0] val_a      [0:MAXC];
    logic       busy_a     [0:MAXC];
    logic       done_a     [0:MAXC];

    systolic_psum_ctrl #(.BIT_ADDR(10), .PE_COL(4)) dut (
        .CLK                (CLK),
        .RST                (RST),
        .i_Start            (i_Start),
        .i_Init             (i_Init),
        .i_Base_Addr        (i_Base_Addr),
        .i_Num_Rows         (i_Num_Rows),
        .i_Stall            (i_Stall),
        .o_Psram_Addr       (o_Psram_Addr),
        .o_Psram_Addr_1buf  (o_Psram_Addr_1buf),
        .o_Psram_En         (o_Psram_En),
        .o_Psram_Wea        (o_Psram_Wea),
        .o_Psram_Valid_1buf (o_Psram_Valid_1buf),
        .o_Busy             (o_Busy),
        .o_Done             (o_Done)
    );

    // Clock/reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_masks();
        for (int i = 0; i <= MAXC; i++) begin
            stall_mask[i] = 1'b0;
            inj_mask[i]   = 1'b0;
        end
    endtask

    // Called at posedge+1. Start is presented in cycle 0; cycles 1..ncyc are captured
    // at the falling edge, with stall/injected starts driven per the masks.
    task automatic run_pass(input logic init, input logic [9:0] base, input logic [9:0] n,
                            input int ncyc);
        i_Start = 1'b1; i_Init = init; i_Base_Addr = base; i_Num_Rows = n; i_Stall = 1'b0;
        @(posedge CLK);
        for (int c = 1; c <= ncyc; c++) begin
            #1;
            i_Stall = stall_mask[c];
            i_Start = inj_mask[c];
            if (inj_mask[c]) begin
                i_Init = 1'b1; i_Base_Addr = 10'h200; i_Num_Rows = 10'd7;
            end
            @(negedge CLK);
            addr_a[c] = o_Psram_Addr;  addr1_a[c] = o_Psram_Addr_1buf;
            en_a[c]   = o_Psram_En;    wea_a[c]   = o_Psram_Wea;
            val_a[c]  = o_Psram_Valid_1buf;
            busy_a[c] = o_Busy;        done_a[c]  = o_Done;
            @(posedge CLK);
        end
        #1;
        i_Start = 1'b0; i_Stall = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; i_Start = 1'b0; i_Init = 1'b0; i_Base_Addr = '0; i_Num_Rows = '0; i_Stall = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({o_Psram_Addr, o_Psram_Addr_1buf, o_Psram_En, o_Psram_Wea, o_Psram_Valid_1buf,
             o_Busy, o_Done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%h a1=%h en=%h wea=%h val=%h busy=%b done=%b, required all 0",
                     o_Psram_Addr, o_Psram_Addr_1buf, o_Psram_En, o_Psram_Wea, o_Psram_Valid_1buf,
                     o_Busy, o_Done);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_basic_run();
        clear_masks();
        run_pass(1'b0, 10'h010, 10'd3, 10);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (en_a[c] !== 4'hF || wea_a[c] !== 4'h0 || addr_a[c] !== 10'h010 + 10'(c - 1)) begin
                errors++;
                $display("FAIL basic_issue c%0d: en=%h wea=%h addr=%h, required en=f wea=0 addr=%h",
                         c, en_a[c], wea_a[c], addr_a[c], 10'h010 + 10'(c - 1));
            end
        end
        for (int c = 2; c <= 4; c++) begin
            checks++;
            if (val_a[c] !== 4'hF || addr1_a[c] !== 10'h010 + 10'(c - 2)) begin
                errors++;
                $display("FAIL basic_wb c%0d: val=%h a1=%h, required val=f a1=%h",
                         c, val_a[c], addr1_a[c], 10'h010 + 10'(c - 2));
            end
        end
        checks++;
        if (en_a[4] !== 4'h0 || val_a[5] !== 4'h0 || busy_a[7] !== 1'b1) begin
            errors++;
            $display("FAIL basic_drain: en4=%h val5=%h busy7=%b, required 0 0 1", en_a[4], val_a[5], busy_a[7]);
        end
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (done_a[c] !== (c == 8)) begin
                errors++;
                $display("FAIL basic_done c%0d: done=%b, required %b", c, done_a[c], c == 8);
            end
        end
        checks++;
        if (busy_a[8] !== 1'b1 || busy_a[9] !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy8=%b busy9=%b, required 1 0", busy_a[8], busy_a[9]);
        end
    endtask

    task automatic test_init_clear();
        clear_masks();
        run_pass(1'b1, 10'h020, 10'd2, 10);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (en_a[c] !== 4'hF || wea_a[c] !== ((c <= 2) ? 4'hF : 4'h0) ||
                addr_a[c] !== 10'h020 + 10'((c - 1) % 2)) begin
                errors++;
                $display("FAIL init_issue c%0d: en=%h wea=%h addr=%h", c, en_a[c], wea_a[c], addr_a[c]);
            end
        end
        for (int c = 2; c <= 6; c++) begin
            checks++;
            if (val_a[c] !== ((c == 4 || c == 5) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL init_valid c%0d: val=%h, required %h", c, val_a[c],
                         (c == 4 || c == 5) ? 4'hF : 4'h0);
            end
        end
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (done_a[c] !== (c == 9)) begin
                errors++;
                $display("FAIL init_done c%0d: done=%b, required %b", c, done_a[c], c == 9);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [9:0] exp_addr [1:4];
        exp_addr[1] = 10'h3FE; exp_addr[2] = 10'h3FF; exp_addr[3] = 10'h000; exp_addr[4] = 10'h001;
        clear_masks();
        run_pass(1'b0, 10'h3FE, 10'd4, 10);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (en_a[c] !== 4'hF || addr_a[c] !== exp_addr[c]) begin
                errors++;
                $display("FAIL wrap_addr c%0d: en=%h addr=%h, required f %h", c, en_a[c], addr_a[c], exp_addr[c]);
            end
        end
        checks++;
        if (addr1_a[5] !== 10'h001 || done_a[9] !== 1'b1 || done_a[8] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_tail: a1_5=%h done8=%b done9=%b, required 001 0 1", addr1_a[5], done_a[8], done_a[9]);
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp_en;
        logic [9:0] exp_addr;
        int issued;
        clear_masks();
        stall_mask[2] = 1'b1; stall_mask[3] = 1'b1;
        run_pass(1'b0, 10'h100, 10'd5, 13);
        issued = 0;
        for (int c = 1; c <= 7; c++) begin
            exp_en   = (c == 2 || c == 3) ? 4'h0 : 4'hF;
            exp_addr = 10'h100 + 10'((c <= 3) ? ((c == 1) ? 0 : 1) : c - 3);
            if (en_a[c] == 4'hF) issued++;
            checks++;
            if (en_a[c] !== exp_en || addr_a[c] !== exp_addr || wea_a[c] !== 4'h0) begin
                errors++;
                $display("FAIL stall_issue c%0d: en=%h addr=%h wea=%h, required %h %h 0",
                         c, en_a[c], addr_a[c], wea_a[c], exp_en, exp_addr);
            end
        end
        checks++;
        if (issued != 5 || val_a[3] !== 4'h0 || val_a[4] !== 4'h0 || val_a[5] !== 4'hF || val_a[8] !== 4'hF) begin
            errors++;
            $display("FAIL stall_valid: issued=%0d val3=%h val4=%h val5=%h val8=%h, required 5 0 0 f f",
                     issued, val_a[3], val_a[4], val_a[5], val_a[8]);
        end
        for (int c = 8; c <= 13; c++) begin
            checks++;
            if (done_a[c] !== (c == 12)) begin
                errors++;
                $display("FAIL stall_done c%0d: done=%b, required %b", c, done_a[c], c == 12);
            end
        end
    endtask

    task automatic test_zero_and_ignored_start();
        clear_masks();
        run_pass(1'b0, 10'h055, 10'd0, 2);
        checks++;
        if (done_a[1] !== 1'b1 || busy_a[1] !== 1'b1 || en_a[1] !== 4'h0 || val_a[2] !== 4'h0 ||
            done_a[2] !== 1'b0 || busy_a[2] !== 1'b0) begin
            errors++;
            $display("FAIL zero_rows: done1=%b busy1=%b en1=%h val2=%h done2=%b busy2=%b, required 1 1 0 0 0 0",
                     done_a[1], busy_a[1], en_a[1], val_a[2], done_a[2], busy_a[2]);
        end
        clear_masks();
        inj_mask[2] = 1'b1; inj_mask[8] = 1'b1;
        run_pass(1'b0, 10'h040, 10'd3, 10);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (en_a[c] !== 4'hF || wea_a[c] !== 4'h0 || addr_a[c] !== 10'h040 + 10'(c - 1)) begin
                errors++;
                $display("FAIL ignored_start c%0d: en=%h wea=%h addr=%h, required f 0 %h",
                         c, en_a[c], wea_a[c], addr_a[c], 10'h040 + 10'(c - 1));
            end
        end
        checks++;
        if (en_a[4] !== 4'h0 || done_a[8] !== 1'b1 || busy_a[9] !== 1'b0 || busy_a[10] !== 1'b0) begin
            errors++;
            $display("FAIL ignored_tail: en4=%h done8=%b busy9=%b busy10=%b, required 0 1 0 0",
                     en_a[4], done_a[8], busy_a[9], busy_a[10]);
        end
    endtask

    task automatic test_async_reset();
        int done_seen;
        clear_masks();
        run_pass(1'b0, 10'h080, 10'd10, 3);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({o_Psram_Addr, o_Psram_Addr_1buf, o_Psram_En, o_Psram_Wea, o_Psram_Valid_1buf,
             o_Busy, o_Done} !== '0) begin
            errors++;
            $display("FAIL async_reset: addr=%h a1=%h en=%h wea=%h val=%h busy=%b done=%b, required all 0",
                     o_Psram_Addr, o_Psram_Addr_1buf, o_Psram_En, o_Psram_Wea, o_Psram_Valid_1buf,
                     o_Busy, o_Done);
        end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (o_Done || o_Busy) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: busy/done cycles=%0d, required 0", done_seen);
        end
        @(posedge CLK);
        #1;
        clear_masks();
        run_pass(1'b0, 10'h005, 10'd1, 7);
        checks++;
        if (en_a[1] !== 4'hF || addr_a[1] !== 10'h005 || val_a[2] !== 4'hF || done_a[6] !== 1'b1 ||
            done_a[5] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_pass: en1=%h addr1=%h val2=%h done5=%b done6=%b, required f 005 f 0 1",
                     en_a[1], addr_a[1], val_a[2], done_a[5], done_a[6]);
        end
    endtask

    task automatic test_max_count();
        clear_masks();
        run_pass(1'b0, 10'h000, 10'h3FF, 1030);
        checks++;
        if (en_a[1023] !== 4'hF || addr_a[1023] !== 10'h3FE || en_a[1024] !== 4'h0) begin
            errors++;
            $display("FAIL max_last: en1023=%h addr1023=%h en1024=%h, required f 3fe 0",
                     en_a[1023], addr_a[1023], en_a[1024]);
        end
        checks++;
        if (done_a[1028] !== 1'b1 || done_a[1027] !== 1'b0 || busy_a[1029] !== 1'b0) begin
            errors++;
            $display("FAIL max_done: done1027=%b done1028=%b busy1029=%b, required 0 1 0",
                     done_a[1027], done_a[1028], busy_a[1029]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_init_clear();
        test_addr_wrap();
        test_stall();
        test_zero_and_ignored_start();
        test_async_reset();
        test_max_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
